// File: rtl/ffd_univ_reg.sv
// ffd_univ_reg: WIDTH-bit bank of D flip-flops with a mode selector.
// Modes cover hold, parallel load, shift/rotate in both directions, and
// up/down counting with a terminal-count flag. All state changes happen on
// the rising clock edge; reset is synchronous and overrides everything else.
module ffd_univ_reg #(
  parameter int                 WIDTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             tc,
  output logic             zero
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101,
    MODE_CNTUP = 3'b110,
    MODE_CNTDN = 3'b111
  } mode_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  mode_t            mode_s;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  assign mode_s = mode_t'(mode);

  // Next-state selection: en=0 or HOLD keeps the current contents.
  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode_s)
        MODE_HOLD:  q_d = q_q;
        MODE_LOAD:  q_d = d;
        MODE_SHL:   q_d = {q_q[WIDTH-2:0], sin};
        MODE_SHR:   q_d = {sin, q_q[WIDTH-1:1]};
        MODE_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
        MODE_CNTUP: q_d = q_q + ONE;
        MODE_CNTDN: q_d = q_q - ONE;
        default:    q_d = q_q;
      endcase
    end
  end

  // State register; synchronous reset takes priority over en and mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  // Status outputs are purely combinational from q (and mode for tc), so tc
  // stays asserted while counting is paused at the terminal value.
  always_comb begin
    tc = 1'b0;
    if (mode_s == MODE_CNTUP && (&q_q)) tc = 1'b1;
    if (mode_s == MODE_CNTDN && (q_q == '0)) tc = 1'b1;
  end

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign zero   = (q_q == '0);

endmodule

// File: tb/tb_ffd_univ_reg.sv
// Testbench for ffd_univ_reg: directed vector table, hand-written corner
// sequences, then randomized traffic against an arithmetic reference model.
module tb_ffd_univ_reg;

  // ---------------- clock / reset block ----------------
  logic       clk = 1'b0;
  logic       reset, en, sin;
  logic [2:0] mode;
  logic [3:0] d;

  logic [3:0] q_a, q_b;
  logic       sout_l_a, sout_r_a, tc_a, zero_a;
  logic       sout_l_b, sout_r_b, tc_b, zero_b;

  always #5 clk = ~clk;

  ffd_univ_reg #(.WIDTH(4), .RESET_VAL(4'b0000)) dut_a (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d), .sin(sin),
    .q(q_a), .sout_l(sout_l_a), .sout_r(sout_r_a), .tc(tc_a), .zero(zero_a)
  );

  ffd_univ_reg #(.WIDTH(4), .RESET_VAL(4'b0101)) dut_b (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d), .sin(sin),
    .q(q_b), .sout_l(sout_l_b), .sout_r(sout_r_b), .tc(tc_b), .zero(zero_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic e, input logic [2:0] m,
                       input logic [3:0] dd, input logic s);
    reset = r; en = e; mode = m; d = dd; sin = s;
  endtask

  // Advance one active edge and settle a little after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Works on plain integers in 0..15, following the mode rules directly.
  function automatic int model_next(int cur, int m, int dd, int s);
    case (m)
      0: return cur;
      1: return dd;
      2: return (cur * 2 + s) % 16;
      3: return cur / 2 + s * 8;
      4: return (cur * 2) % 16 + cur / 8;
      5: return cur / 2 + (cur % 2) * 8;
      6: return (cur + 1) % 16;
      default: return (cur + 15) % 16;
    endcase
  endfunction

  function automatic int model_tc(int cur, int m);
    return ((m == 6 && cur == 15) || (m == 7 && cur == 0)) ? 1 : 0;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [3:0] d;
    logic       sin;
    logic [3:0] eq;
    logic       etc;
    logic       ez;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic e, logic [2:0] m, logic [3:0] dd,
                              logic s, logic [3:0] eq, logic etc, logic ez);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.d = dd; v.sin = s;
    v.eq = eq; v.etc = etc; v.ez = ez;
    return v;
  endfunction

  int ma, mb;

  initial begin
    drive(1'b1, 1'b0, 3'b000, 4'b0000, 1'b0);

    // reset and hold
    vecs.push_back(mk(1, 1, 3'b001, 4'b1010, 0, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 1, 3'b001, 4'b1010, 0, 4'b1010, 0, 0));
    vecs.push_back(mk(0, 0, 3'b001, 4'b0101, 0, 4'b1010, 0, 0));
    vecs.push_back(mk(0, 0, 3'b001, 4'b0101, 0, 4'b1010, 0, 0));
    vecs.push_back(mk(0, 0, 3'b001, 4'b0101, 0, 4'b1010, 0, 0));
    // shift with serial input
    vecs.push_back(mk(0, 1, 3'b001, 4'b0000, 0, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 1, 3'b010, 4'b0000, 1, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 1, 3'b010, 4'b0000, 1, 4'b0011, 0, 0));
    vecs.push_back(mk(0, 1, 3'b010, 4'b0000, 0, 4'b0110, 0, 0));
    vecs.push_back(mk(0, 1, 3'b010, 4'b0000, 1, 4'b1101, 0, 0));
    vecs.push_back(mk(0, 1, 3'b011, 4'b0000, 0, 4'b0110, 0, 0));
    vecs.push_back(mk(0, 1, 3'b011, 4'b0000, 0, 4'b0011, 0, 0));
    // rotate round trip
    vecs.push_back(mk(0, 1, 3'b001, 4'b1000, 0, 4'b1000, 0, 0));
    vecs.push_back(mk(0, 1, 3'b100, 4'b0000, 1, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 1, 3'b100, 4'b0000, 0, 4'b0010, 0, 0));
    vecs.push_back(mk(0, 1, 3'b100, 4'b0000, 1, 4'b0100, 0, 0));
    vecs.push_back(mk(0, 1, 3'b100, 4'b0000, 0, 4'b1000, 0, 0));
    vecs.push_back(mk(0, 1, 3'b101, 4'b0000, 1, 4'b0100, 0, 0));
    // count-up wrap and tc, paused at terminal value
    vecs.push_back(mk(0, 1, 3'b001, 4'b1110, 0, 4'b1110, 0, 0));
    vecs.push_back(mk(0, 0, 3'b110, 4'b0000, 0, 4'b1110, 0, 0));
    vecs.push_back(mk(0, 1, 3'b110, 4'b0000, 0, 4'b1111, 1, 0));
    vecs.push_back(mk(0, 1, 3'b110, 4'b0000, 0, 4'b0000, 0, 1));
    vecs.push_back(mk(0, 1, 3'b111, 4'b0000, 0, 4'b1111, 0, 0));
    vecs.push_back(mk(0, 0, 3'b110, 4'b0000, 0, 4'b1111, 1, 0));
    vecs.push_back(mk(0, 0, 3'b110, 4'b0000, 0, 4'b1111, 1, 0));
    // count-down wrap
    vecs.push_back(mk(0, 1, 3'b001, 4'b0001, 0, 4'b0001, 0, 0));
    vecs.push_back(mk(0, 1, 3'b111, 4'b0000, 0, 4'b0000, 1, 1));
    vecs.push_back(mk(0, 1, 3'b111, 4'b0000, 0, 4'b1111, 0, 0));
    // reset beats en and mode; tc follows q and mode under reset
    vecs.push_back(mk(1, 1, 3'b110, 4'b1111, 1, 4'b0000, 0, 1));
    vecs.push_back(mk(1, 1, 3'b111, 4'b1111, 1, 4'b0000, 1, 1));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sin);
      step();
      exp_q.push_back(vecs[i].eq);
      chk($sformatf("vec%0d_q", i), q_a, exp_q.pop_front());
      chk($sformatf("vec%0d_tc", i), {3'b000, tc_a}, {3'b000, vecs[i].etc});
      chk($sformatf("vec%0d_zero", i), {3'b000, zero_a}, {3'b000, vecs[i].ez});
      chk($sformatf("vec%0d_sout_l", i), {3'b000, sout_l_a}, {3'b000, vecs[i].eq[3]});
      chk($sformatf("vec%0d_sout_r", i), {3'b000, sout_r_a}, {3'b000, vecs[i].eq[0]});
    end

    // reset asserted between edges must not touch q until the next edge
    drive(0, 1, 3'b001, 4'b1010, 0);
    step();
    drive(1, 1, 3'b110, 4'b0000, 0);
    #3;
    chk("no_async_reset", q_a, 4'b1010);
    step();
    chk("sync_reset_applied", q_a, 4'b0000);

    // mode change between edges: tc reacts, q does not
    drive(0, 0, 3'b111, 4'b1111, 1);
    #1;
    chk("tc_comb_cntdn", {3'b000, tc_a}, 4'b0001);
    mode = 3'b110;
    #1;
    chk("tc_comb_cntup", {3'b000, tc_a}, 4'b0000);
    chk("q_steady_midcycle", q_a, 4'b0000);

    // RESET_VAL instance: reset mid-count
    drive(1, 0, 3'b000, 4'b0000, 0);
    step();
    chk("rv_reset", q_b, 4'b0101);
    drive(0, 1, 3'b001, 4'b0000, 0);
    step();
    drive(0, 1, 3'b110, 4'b0000, 0);
    step(); step(); step();
    chk("rv_count3", q_b, 4'b0011);
    drive(1, 1, 3'b110, 4'b0000, 0);
    step();
    chk("rv_midcount_reset", q_b, 4'b0101);
    drive(0, 1, 3'b110, 4'b0000, 0);
    step();
    chk("rv_resume", q_b, 4'b0110);

    // randomized traffic against the reference model
    drive(1, 0, 3'b000, 4'b0000, 0);
    step();
    ma = 0;
    mb = 5;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)));
      if (reset) begin
        ma = 0;
        mb = 5;
      end else if (en) begin
        ma = model_next(ma, int'(mode), int'(d), int'(sin));
        mb = model_next(mb, int'(mode), int'(d), int'(sin));
      end
      step();
      chk("rnd_q_a", q_a, 4'(ma));
      chk("rnd_q_b", q_b, 4'(mb));
      chk("rnd_tc_a", {3'b000, tc_a}, 4'(model_tc(ma, int'(mode))));
      chk("rnd_tc_b", {3'b000, tc_b}, 4'(model_tc(mb, int'(mode))));
      chk("rnd_zero_a", {3'b000, zero_a}, (ma == 0) ? 4'd1 : 4'd0);
      chk("rnd_zero_b", {3'b000, zero_b}, (mb == 0) ? 4'd1 : 4'd0);
      chk("rnd_sout_l_a", {3'b000, sout_l_a}, 4'(ma / 8));
      chk("rnd_sout_r_b", {3'b000, sout_r_b}, 4'(mb % 2));
      chk("rnd_sout_l_b", {3'b000, sout_l_b}, 4'(mb / 8));
      chk("rnd_sout_r_a", {3'b000, sout_r_a}, 4'(ma % 2));
    end

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ffd_univ_reg.md
Name: ffd_univ_reg

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit bank of D flip-flops with a mode selector.
- Modes: hold, parallel load, shift left/right with serial input, rotate left/right, and count up/down with a terminal-count flag.
- Serves as the general-purpose state element for later labs (shift registers, counters, sequence detectors), replacing per-bit flip-flop instantiation.

Parameters:
- WIDTH, 4, number of flip-flop stages (minimum 2).
- RESET_VAL, 0, value loaded into q on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock; all state changes on posedge clk.
- reset  input  1  synchronous, active-high reset.
- en  input  1  clock enable; 0 = hold regardless of mode.
- mode  input  3  operation select (encoding below).
- d  input  WIDTH  parallel load data.
- sin  input  1  serial input for shift modes.
- q  output  WIDTH  register contents.
- sout_l  output  1  equals q[WIDTH-1] (combinational from q).
- sout_r  output  1  equals q[0] (combinational from q).
- tc  output  1  terminal count flag (combinational from q and mode).
- zero  output  1  1 when q == 0 (combinational).

Behaviour:
- Reset value is fixed by the interface: one clock, synchronous active-high reset.
  - reset=1 at posedge clk: q <= RESET_VAL.
  - Reset has priority over en and mode.
  - No asynchronous path: asserting reset between edges does not change q until the next posedge.
  - Reset mid-operation, e.g. mid-count or mid-shift: the operation is discarded and q = RESET_VAL after that edge.
  - Operation resumes on the first edge with reset=0.
- Output values under reset: q=RESET_VAL; sout_l, sout_r, zero and tc follow from q; tc also depends on mode.
- en=0 (reset=0): q holds.
- en=1, reset=0, per mode, all with one-cycle latency (q updates at the edge where inputs are sampled):
  - 000 HOLD: q <= q.
  - 001 LOAD: q <= d.
  - 010 SHL: q <= {q[WIDTH-2:0], sin}; bit WIDTH-1 is lost.
  - 011 SHR: q <= {sin, q[WIDTH-1:1]}; bit 0 is lost.
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; sin ignored.
  - 101 ROR: q <= {q[0], q[WIDTH-1:1]}; sin ignored.
  - 110 CNTUP: q <= q + 1, modulo 2^WIDTH; all-ones wraps to 0.
  - 111 CNTDN: q <= q - 1, modulo 2^WIDTH; 0 wraps to all-ones.
- tc:
  - 1 when mode=110 and q = all-ones.
  - 1 when mode=111 and q = 0.
  - 0 otherwise.
  - tc does not depend on en, so it stays asserted while counting is paused at the terminal value.
- Arithmetic is unsigned, WIDTH bits; no carry or borrow output beyond tc.
- d, sin and mode are sampled only at posedge clk. Changes between edges have no effect on q; they affect tc combinationally only through mode.
- Mode may change on any cycle. The next edge applies the new mode to the current q; there are no pipeline stages and no mode-change penalty.
- Simultaneous reset=1 and en=1 with any mode: reset wins.
- X/Z on mode while en=1: not supported; the bench keeps mode defined.

Test Plan (WIDTH=4, RESET_VAL=0 unless stated):
- Reset and hold:
  - mode=001, d=1010, en=1, reset=1 for one edge -> q=0000, zero=1.
  - Release reset -> next edge q=1010.
  - Set en=0, change d=0101 -> q stays 1010 across 3 edges.
- Shift with serial input:
  - Load 0000, mode=010, sin sequence 1,1,0,1 over 4 edges -> q=1101, sout_l=1.
  - Then mode=011, sin=0, 2 edges -> q=0011, sout_r=1.
- Rotate round trip:
  - Load 1000, mode=100 -> after 1 edge q=0001.
  - After 4 edges total q=1000.
  - mode=101 from 1000 -> after 1 edge q=0100.
- Count-up wrap and tc:
  - Load 1110, mode=110 -> tc=0.
  - Edge -> q=1111, tc=1.
  - Edge -> q=0000, tc=0, zero=1.
  - Set en=0 at q=1111 -> tc stays 1, q holds.
- Count-down wrap:
  - Load 0001, mode=111 -> edge q=0000, tc=1.
  - Edge -> q=1111, tc=0.
- Reset mid-count and RESET_VAL:
  - Instance with RESET_VAL=0101: count up from 0000 for 3 edges (q=0011).
  - Assert reset for one edge -> q=0101.
  - Deassert -> next edge q=0110.
